// File: rtl/alu_pkg.sv
// Shared ALU op codes, legality check and arbiter FSM state encoding.
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_NOR  = 4'b0100;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SADD = 4'b1011;
  localparam logic [3:0] ALU_SSUB = 4'b1100;
  localparam logic [3:0] ALU_NOP  = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  function automatic logic is_legal_op(input logic [3:0] code);
    case (code)
      ALU_AND, ALU_OR, ALU_ADD, ALU_XOR, ALU_NOR, ALU_SUB,
      ALU_SLT, ALU_SLL, ALU_SRL, ALU_SADD, ALU_SSUB: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first request at or above ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      idx,
  output logic               any
);

  // scan NUM_REQ positions starting at ptr, first hit wins
  always_comb begin
    int j;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(ptr) + k) % NUM_REQ;
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external ALU between NUM_REQ requesters: IDLE grants, EXEC drives
// the ALU and captures its outputs, RESP holds the response until accepted.
// Optional macro ALU_ARB_STICKY_OVF_EN adds per-requester sticky overflow bits.
//
// state | meaning
// IDLE  | ALU at NOP, round-robin grant of one request
// EXEC  | ALU driven from latched op, outputs captured at cycle end
// RESP  | rsp_valid to granted requester until its rsp_ready
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [4*NUM_REQ-1:0]     req_control,
  input  logic [WIDTH*NUM_REQ-1:0] req_operand0,
  input  logic [WIDTH*NUM_REQ-1:0] req_operand1,
  output logic [NUM_REQ-1:0]       rsp_valid,
  input  logic [NUM_REQ-1:0]       rsp_ready,
  output logic [WIDTH-1:0]         rsp_result,
  output logic                     rsp_overflow,
  output logic                     rsp_zero,
  output logic                     rsp_error,
  output logic [3:0]               alu_control,
  output logic [WIDTH-1:0]         alu_operand0,
  output logic [WIDTH-1:0]         alu_operand1,
  input  logic [WIDTH-1:0]         alu_result,
  input  logic                     alu_overflow,
  input  logic                     alu_zero
`ifdef ALU_ARB_STICKY_OVF_EN
  ,
  output logic [NUM_REQ-1:0]       ovf_sticky,
  input  logic [NUM_REQ-1:0]       ovf_clear
`endif
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e          state, state_nxt;
  logic [IW-1:0]       ptr, gidx;
  logic [3:0]          lat_ctrl;
  logic [WIDTH-1:0]    lat_op0, lat_op1;
  logic                lat_legal;
  logic [NUM_REQ-1:0]  arb_grant;
  logic [IW-1:0]       arb_idx;
  logic                arb_any;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  // next state and all combinational outputs; ALU parked at NOP/0 outside EXEC
  always_comb begin
    state_nxt    = state;
    req_ready    = '0;
    rsp_valid    = '0;
    alu_control  = ALU_NOP;
    alu_operand0 = '0;
    alu_operand1 = '0;
    case (state)
      IDLE: begin
        if (!reset) req_ready = arb_grant;
        if (arb_any) state_nxt = EXEC;
      end
      EXEC: begin
        if (lat_legal) begin
          alu_control  = lat_ctrl;
          alu_operand0 = lat_op0;
          alu_operand1 = lat_op1;
        end
        state_nxt = RESP;
      end
      RESP: begin
        rsp_valid[gidx] = 1'b1;
        if (rsp_ready[gidx]) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // latch the winning request and advance the round-robin pointer on grant
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr       <= '0;
      gidx      <= '0;
      lat_ctrl  <= ALU_NOP;
      lat_op0   <= '0;
      lat_op1   <= '0;
      lat_legal <= 1'b0;
    end else if (state == IDLE && arb_any) begin
      gidx      <= arb_idx;
      lat_ctrl  <= req_control[4*int'(arb_idx) +: 4];
      lat_op0   <= req_operand0[WIDTH*int'(arb_idx) +: WIDTH];
      lat_op1   <= req_operand1[WIDTH*int'(arb_idx) +: WIDTH];
      lat_legal <= is_legal_op(req_control[4*int'(arb_idx) +: 4]);
      ptr       <= (arb_idx == IW'(NUM_REQ-1)) ? '0 : arb_idx + 1'b1;
    end
  end

  // capture ALU outputs at the end of EXEC; illegal ops report a clean error
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_result   <= '0;
      rsp_overflow <= 1'b0;
      rsp_zero     <= 1'b0;
      rsp_error    <= 1'b0;
    end else if (state == EXEC) begin
      rsp_result   <= lat_legal ? alu_result   : '0;
      rsp_overflow <= lat_legal ? alu_overflow : 1'b0;
      rsp_zero     <= lat_legal ? alu_zero     : 1'b0;
      rsp_error    <= ~lat_legal;
    end
  end

`ifdef ALU_ARB_STICKY_OVF_EN
  // sticky overflow per requester; a completing overflow beats a clear
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_sticky <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (rsp_valid[i] && rsp_ready[i] && rsp_overflow) ovf_sticky[i] <= 1'b1;
        else if (ovf_clear[i])                           ovf_sticky[i] <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a behavioural ALU and arbitration model.
module tb_alu_arbiter;

  localparam int N = 2;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
  logic [4*N-1:0] req_control;
  logic [W*N-1:0] req_operand0, req_operand1;
  logic [W-1:0]   rsp_result, alu_operand0, alu_operand1, alu_result;
  logic           rsp_overflow, rsp_zero, rsp_error, alu_overflow, alu_zero;
  logic [3:0]     alu_control;
`ifdef ALU_ARB_STICKY_OVF_EN
  logic [N-1:0]   ovf_sticky, ovf_clear;
`endif

  always #5 clk = ~clk;

  alu_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_control(req_control),
    .req_operand0(req_operand0), .req_operand1(req_operand1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_overflow(rsp_overflow), .rsp_zero(rsp_zero),
    .rsp_error(rsp_error),
    .alu_control(alu_control), .alu_operand0(alu_operand0), .alu_operand1(alu_operand1),
    .alu_result(alu_result), .alu_overflow(alu_overflow), .alu_zero(alu_zero)
`ifdef ALU_ARB_STICKY_OVF_EN
    , .ovf_sticky(ovf_sticky), .ovf_clear(ovf_clear)
`endif
  );

  function automatic logic legal_op(input logic [3:0] op);
    return op inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h6, 4'h7, 4'h8, 4'h9, 4'hB, 4'hC};
  endfunction

  function automatic void alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output logic v);
    v = 1'b0;
    case (op)
      4'h0: r = a & b;
      4'h1: r = a | b;
      4'h2: r = a + b;
      4'h3: r = a ^ b;
      4'h4: r = ~(a | b);
      4'h6: r = a - b;
      4'h7: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'h8: r = a << b[4:0];
      4'h9: r = a >> b[4:0];
      4'hB: begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
      4'hC: begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
      default: begin r = 32'hDEADBEEF; v = 1'b1; end
    endcase
  endfunction

  // external ALU stand-in; NOP yields junk so masking of illegal ops is visible
  always_comb begin
    logic [31:0] r;
    logic        v;
    alu_fn(alu_control, alu_operand0, alu_operand1, r, v);
    alu_result   = r;
    alu_overflow = v;
    alu_zero     = (r == 32'd0);
  end

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    logic        zero;
    logic        err;
  } exp_t;

  exp_t        q[$];
  int          grants[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          n_accepts = 0;
  logic        busy = 1'b0;
  int          since = 0;
  int          mptr = 0;
  int          gwho = 0;
  logic        prev_rst = 1'b0;
  logic [3:0]  e_ctrl;
  logic [31:0] e_op0, e_op1;
  logic [N-1:0] sticky_m = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // monitor/model: samples on the falling edge, checks, then advances the model
  always @(negedge clk) begin
    logic [N-1:0] exp_rdy;
    int           w;
    logic [3:0]   op;
    logic [31:0]  a, b, r;
    logic         v;
    logic         fire;
    exp_t         e;
    if (reset) begin
      if (prev_rst) begin
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", {rsp_result, rsp_overflow, rsp_zero, rsp_error}, 0);
        chk("rst_alu_ctrl", alu_control, 4'hF);
        chk("rst_alu_ops", {alu_operand0, alu_operand1}, 0);
`ifdef ALU_ARB_STICKY_OVF_EN
        chk("rst_sticky", ovf_sticky, 0);
`endif
      end
      q.delete();
      busy = 1'b0; since = 0; mptr = 0; sticky_m = '0;
      prev_rst = 1'b1;
    end else begin
      prev_rst = 1'b0;
      since++;
      exp_rdy = '0;
      w = -1;
      if (!busy) begin
        for (int k = 0; k < N; k++) begin
          if (w < 0 && req_valid[(mptr + k) % N]) w = (mptr + k) % N;
        end
        if (w >= 0) exp_rdy[w] = 1'b1;
      end
      chk("req_ready", req_ready, exp_rdy);
      chk("rsp_valid", rsp_valid, (busy && since >= 2) ? (N'(1) << gwho) : N'(0));
      if (busy && since == 1) begin
        chk("alu_control", alu_control, e_ctrl);
        chk("alu_operands", {alu_operand0, alu_operand1}, {e_op0, e_op1});
      end else begin
        chk("alu_idle_ctrl", alu_control, 4'hF);
        chk("alu_idle_ops", {alu_operand0, alu_operand1}, 0);
      end
`ifdef ALU_ARB_STICKY_OVF_EN
      chk("ovf_sticky", ovf_sticky, sticky_m);
`endif
      fire = 1'b0;
      if (busy && since >= 2) begin
        if (q.size() == 0) begin
          chk("scoreboard_empty", 1, 0);
        end else begin
          e = q[0];
          chk("rsp_data", {rsp_result, rsp_overflow, rsp_zero, rsp_error},
              {e.res, e.ovf, e.zero, e.err});
          if (rsp_ready[gwho]) begin
            fire = 1'b1;
            void'(q.pop_front());
            busy = 1'b0;
          end
        end
      end
`ifdef ALU_ARB_STICKY_OVF_EN
      for (int i = 0; i < N; i++) begin
        if (fire && i == gwho && e.ovf) sticky_m[i] = 1'b1;
        else if (ovf_clear[i])          sticky_m[i] = 1'b0;
      end
`endif
      if (w >= 0) begin
        op = req_control[4*w +: 4];
        a  = req_operand0[W*w +: W];
        b  = req_operand1[W*w +: W];
        if (legal_op(op)) begin
          alu_fn(op, a, b, r, v);
          e.res = r; e.ovf = v; e.zero = (r == 0); e.err = 1'b0;
          e_ctrl = op; e_op0 = a; e_op1 = b;
        end else begin
          e.res = 0; e.ovf = 1'b0; e.zero = 1'b0; e.err = 1'b1;
          e_ctrl = 4'hF; e_op0 = 0; e_op1 = 0;
        end
        q.push_back(e);
        grants.push_back(w);
        busy = 1'b1; since = 0; gwho = w; mptr = (w + 1) % N;
        n_accepts++;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    req_control[4*i +: 4]  = op;
    req_operand0[W*i +: W] = a;
    req_operand1[W*i +: W] = b;
  endtask

  initial begin
    int old;
    logic got;
    reset = 1'b1; req_valid = '0; rsp_ready = '0;
    req_control = '1; req_operand0 = '0; req_operand1 = '0;
`ifdef ALU_ARB_STICKY_OVF_EN
    ovf_clear = '0;
`endif
    cyc(3);
    reset = 1'b0;
    cyc(1);

    // single add 5+7 from requester 0
    set_req(0, 4'h2, 32'd5, 32'd7);
    rsp_ready = 2'b11; req_valid = 2'b01;
    cyc(1); req_valid = '0; cyc(5);

    // both requesters continuously valid: grants must alternate
    grants.delete();
    set_req(0, 4'h0, 32'd1, 32'd1);
    set_req(1, 4'h6, 32'd3, 32'd3);
    req_valid = 2'b11;
    cyc(14); req_valid = '0; cyc(4);
    chk("alt_grant_count", (grants.size() >= 4) ? 1 : 0, 1);
    for (int i = 1; i < grants.size(); i++) chk("alt_grant", grants[i], 1 - grants[i-1]);

    // signed overflow with stalled response; req0 waits and must not be granted
    set_req(1, 4'hB, 32'h7FFFFFFF, 32'd1);
    rsp_ready = 2'b00; req_valid = 2'b10;
    cyc(1); req_valid = 2'b11;
    cyc(7);
    rsp_ready = 2'b11; cyc(4);
    req_valid = '0; cyc(4);

    // illegal op then a legal op
    set_req(0, 4'h5, 32'h1234, 32'h5678);
    req_valid = 2'b01; cyc(1); req_valid = '0; cyc(4);
    set_req(0, 4'h2, 32'd1, 32'd2);
    req_valid = 2'b01; cyc(1); req_valid = '0; cyc(4);

    // random traffic
    for (int t = 0; t < 500; t++) begin
      req_valid    = N'($urandom);
      req_control  = (4*N)'($urandom);
      req_operand0 = {$urandom, $urandom};
      req_operand1 = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) req_operand0[W-1:0] = 32'h7FFFFFFF;
      if ($urandom_range(0, 3) == 0) req_operand1[2*W-1:W] = 32'h80000000;
      if ($urandom_range(0, 3) == 0) req_operand1[W-1:0] = 32'd1;
      rsp_ready = N'($urandom);
`ifdef ALU_ARB_STICKY_OVF_EN
      ovf_clear = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
`endif
      cyc(1);
    end
    req_valid = '0; rsp_ready = 2'b11;
`ifdef ALU_ARB_STICKY_OVF_EN
    ovf_clear = '0;
`endif
    cyc(6);

    // reset asserted during EXEC abandons the operation
    set_req(0, 4'h2, 32'd9, 32'd9);
    old = n_accepts; got = 1'b0;
    req_valid = 2'b01;
    for (int t = 0; t < 20 && !got; t++) begin
      cyc(1);
      if (n_accepts != old) got = 1'b1;
    end
    chk("exec_accept_seen", got, 1);
    reset = 1'b1; req_valid = '0;
    cyc(2);
    reset = 1'b0;
    cyc(6);

    // pointer back at 0: requester 0 wins first
    grants.delete();
    set_req(0, 4'h1, 32'hF0, 32'h0F);
    set_req(1, 4'h3, 32'hFF, 32'hFF);
    req_valid = 2'b11; cyc(4); req_valid = '0; cyc(4);
    chk("post_reset_first_grant", (grants.size() > 0) ? grants[0] : -1, 0);
    chk("scoreboard_drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
